divisor_clk_param: RTL and testbench

Parametrised, fully synchronous clock divider and tick generator for the toy-automation timing chain. It replaces ripple-counter dividers that have a fixed terminal count. All state is clocked by the single system clock. The block provides:
- a runtime-loadable divisor, applied glitch-free at period boundaries;
- a clock-enable;
- a one-cycle tick output;
- a selectable pulse or near-50% square output.

Downstream timers and state machines consume `tick` as an enable, never as a clock.

---
 rtl/divisor_clk_param_pkg.sv | 15 +
 rtl/divisor_clk_param_contador.sv | 38 +++
 rtl/divisor_clk_param.sv | 112 +++++++++++
 tb/tb_divisor_clk_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_clk_param_pkg.sv
// Shared constants for the divider: output-mode encoding and the minimum legal divisor.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package divisor_pkg;

  // Output waveform selection for clk_out.
  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  // Divisors below this value cannot produce distinct high/low phases.
  localparam int DIV_MIN = 2;

endpackage

// File: rtl/divisor_clk_param_contador.sv
// Modulo-N enabled up-counter; exposes next count and the wrap condition for the top level.
// Latency: count updates on the rising edge; wrap and next count are combinational from state.
// Backpressure: enable low freezes the count; there is no handshake.
module contador_mod #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_mod,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_nxt,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;

  // Next-count decode: wrap to zero on the last count of the period.
  always_comb begin
    o_wrap      = i_enable && (r_count == (i_mod - WIDTH'(1)));
    o_count_nxt = r_count;
    if (i_enable) begin
      o_count_nxt = o_wrap ? '0 : (r_count + WIDTH'(1));
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_nxt;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/divisor_clk_param.sv
// Runtime-programmable clock divider producing a one-cycle tick and a pulse/square clk_out.
// Latency: all outputs registered; a loaded divisor takes effect at the next wrap edge.
// Backpressure: enable low freezes count/outputs; loads are held pending until an enabled wrap.
module divisor_clk_param
  import divisor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_div_in,
  input  logic             i_div_load,
  input  logic             i_mode_in,
  output logic             o_div_ack,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_div_active
);

  localparam logic [WIDTH-1:0] DIV_RST_C =
    (DIV_RESET < DIV_MIN) ? WIDTH'(DIV_MIN) : WIDTH'(DIV_RESET);

  logic [WIDTH-1:0] r_div_active;
  mode_e            r_mode;
  logic             r_pend_vld;
  logic [WIDTH-1:0] r_pend_div;
  mode_e            r_pend_mode;
  logic             r_tick;
  logic             r_ack;
  logic             r_clk_out;

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap;
  logic [WIDTH-1:0] w_load_div;
  logic             w_activate;
  logic [WIDTH-1:0] w_div_nxt;
  mode_e            w_mode_nxt;
  logic             w_clk_nxt;

  contador_mod #(.WIDTH(WIDTH)) u_cnt (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_mod       (r_div_active),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt),
    .o_wrap      (w_wrap)
  );

  // Clamp, activation select and clk_out decode from the values that will hold after this edge.
  always_comb begin
    w_load_div = (i_div_in < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : i_div_in;
    w_activate = w_wrap && (i_div_load || r_pend_vld);
    w_div_nxt  = r_div_active;
    w_mode_nxt = r_mode;
    if (w_wrap) begin
      // A load arriving on the wrap edge is newer than anything pending, so it wins.
      if (i_div_load) begin
        w_div_nxt  = w_load_div;
        w_mode_nxt = mode_e'(i_mode_in);
      end else if (r_pend_vld) begin
        w_div_nxt  = r_pend_div;
        w_mode_nxt = r_pend_mode;
      end
    end
    if (w_mode_nxt == MODE_SQUARE) begin
      w_clk_nxt = (w_count_nxt >= (w_div_nxt >> 1));
    end else begin
      w_clk_nxt = (w_count_nxt == (w_div_nxt - WIDTH'(1)));
    end
  end

  // Pending/active settings and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_active <= DIV_RST_C;
      r_mode       <= MODE_PULSE;
      r_pend_vld   <= 1'b0;
      r_pend_div   <= '0;
      r_pend_mode  <= MODE_PULSE;
      r_tick       <= 1'b0;
      r_ack        <= 1'b0;
      r_clk_out    <= 1'b0;
    end else begin
      r_div_active <= w_div_nxt;
      r_mode       <= w_mode_nxt;
      r_tick       <= w_wrap;
      r_ack        <= w_activate;
      if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end else if (i_div_load) begin
        r_pend_vld  <= 1'b1;
        r_pend_div  <= w_load_div;
        r_pend_mode <= mode_e'(i_mode_in);
      end
      if (i_enable) begin
        r_clk_out <= w_clk_nxt;
      end
    end
  end

  assign o_div_ack    = r_ack;
  assign o_tick       = r_tick;
  assign o_clk_out    = r_clk_out;
  assign o_count      = w_count;
  assign o_div_active = r_div_active;

endmodule

// File: tb/tb_divisor_clk_param.sv
// Directed bench for divisor_clk_param: per-cycle comparison against a behavioural model plus literal checks.
// Latency: model is evaluated at each rising edge, outputs compared on the falling edge.
// Backpressure: exercised through enable stalls and loads held pending.
module tb_divisor_clk_param;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_enable = 1'b0;
  logic [7:0] i_div_in = 8'd0;
  logic       i_div_load = 1'b0;
  logic       i_mode_in = 1'b0;
  logic       o_div_ack;
  logic       o_tick;
  logic       o_clk_out;
  logic [7:0] o_count;
  logic [7:0] o_div_active;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int n_ack = 0;
  int n_tick = 0;

  // Behavioural model state
  int m_cnt, m_d, m_mode, m_pv, m_pd, m_pm, m_tick, m_ack, m_clk;

  divisor_clk_param #(.WIDTH(8), .DIV_RESET(5)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_div_in     (i_div_in),
    .i_div_load   (i_div_load),
    .i_mode_in    (i_mode_in),
    .o_div_ack    (o_div_ack),
    .o_tick       (o_tick),
    .o_clk_out    (o_clk_out),
    .o_count      (o_count),
    .o_div_active (o_div_active)
  );

  always #5 i_clk = ~i_clk;

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update(input logic en, input logic ld, input int din,
                              input logic mi, input logic rst);
    bit wrap;
    if (rst) begin
      m_cnt = 0; m_d = clampd(5); m_mode = 0; m_pv = 0; m_tick = 0; m_ack = 0;
    end else begin
      wrap   = en && (m_cnt == m_d - 1);
      m_tick = wrap;
      m_ack  = 0;
      if (en) m_cnt = (m_cnt + 1) % m_d;
      if (wrap && ld) begin
        m_d = clampd(din); m_mode = mi; m_ack = 1; m_pv = 0;
      end else if (wrap && m_pv != 0) begin
        m_d = m_pd; m_mode = m_pm; m_ack = 1; m_pv = 0;
      end else if (ld) begin
        m_pv = 1; m_pd = clampd(din); m_pm = mi;
      end
    end
    m_clk = (m_mode != 0) ? int'(m_cnt >= m_d / 2) : int'(m_cnt == m_d - 1);
  endtask

  // One clock: drive inputs, advance model at the rising edge, return at the falling edge.
  task automatic step(input logic en, input logic ld, input int din,
                      input logic mi, input logic rst);
    i_enable   = en;
    i_div_load = ld;
    i_div_in   = din[7:0];
    i_mode_in  = mi;
    i_reset    = rst;
    @(posedge i_clk);
    model_update(en, ld, din, mi, rst);
    chk_en = 1'b1;
    @(negedge i_clk);
    cyc++;
    if (o_div_ack) n_ack++;
    if (o_tick) n_tick++;
    i_div_load = 1'b0;
    i_reset    = 1'b0;
  endtask

  function automatic int cur(input int sel);
    case (sel)
      0:       return int'(o_count);
      1:       return int'(o_div_ack);
      default: return int'(o_tick);
    endcase
  endfunction

  // Step with enable high until the selected output reaches val, bounded.
  task automatic run_until(input string name, input int sel, input int val);
    int n = 0;
    while (cur(sel) != val && n < 200) begin
      step(1, 0, 0, 0, 0);
      n++;
    end
    chk(name, cur(sel), val);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("model_count", int'(o_count), m_cnt);
      chk("model_div_active", int'(o_div_active), m_d);
      chk("model_tick", int'(o_tick), m_tick);
      chk("model_div_ack", int'(o_div_ack), m_ack);
      chk("model_clk_out", int'(o_clk_out), m_clk);
    end
  end

  initial begin
    int t0, a0, start;

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_count", int'(o_count), 0);
    chk("rst_div_active", int'(o_div_active), 5);
    chk("rst_tick", int'(o_tick), 0);
    chk("rst_clk_out", int'(o_clk_out), 0);
    chk("rst_ack", int'(o_div_ack), 0);

    // D=5 pulse mode from reset
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 0, 0, 0);
      chk("s1_tick", int'(o_tick), int'(k % 5 == 0));
      chk("s1_count", int'(o_count), k % 5);
      chk("s1_clk_out", int'(o_clk_out), int'(k % 5 == 4));
    end

    // D=6 square: 3 low, 3 high
    step(1, 1, 6, 1, 0);
    run_until("s2_ack_wait", 1, 1);
    chk("s2_div_active", int'(o_div_active), 6);
    chk("s2_tick_with_ack", int'(o_tick), 1);
    chk("s2_clk_out0", int'(o_clk_out), 0);
    for (int j = 1; j <= 5; j++) begin
      step(1, 0, 0, 0, 0);
      chk("s2_sq6_clk_out", int'(o_clk_out), int'(j >= 3));
    end
    // Load on the wrap edge itself: activates on that edge
    step(1, 1, 5, 1, 0);
    chk("s2_bypass_ack", int'(o_div_ack), 1);
    chk("s2_bypass_div", int'(o_div_active), 5);
    chk("s2_bypass_count", int'(o_count), 0);
    for (int j = 1; j <= 4; j++) begin
      step(1, 0, 0, 0, 0);
      chk("s2_sq5_clk_out", int'(o_clk_out), int'(j >= 2));
    end
    t0 = n_tick;
    repeat (250) step(1, 0, 0, 0, 0);
    chk("s2_50_periods", n_tick - t0, 50);

    // D=5 pulse, load 3 while count=1
    step(1, 1, 5, 0, 0);
    run_until("s3_ack_wait", 1, 1);
    run_until("s3_count1", 0, 1);
    step(1, 1, 3, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("s3_no_early_tick", int'(o_tick), 0);
    step(1, 0, 0, 0, 0);
    chk("s3_no_early_ack", int'(o_div_ack), 0);
    step(1, 0, 0, 0, 0);
    chk("s3_tick_4_later", int'(o_tick), 1);
    chk("s3_ack_coincident", int'(o_div_ack), 1);
    chk("s3_div_active", int'(o_div_active), 3);
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 0, 0, 0);
      chk("s3_period3_tick", int'(o_tick), int'(k % 3 == 0));
    end

    // Clamp loads 0 and 1 to 2
    a0 = n_ack;
    step(1, 1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    chk("s4_ack_once_load0", n_ack - a0, 1);
    chk("s4_clamp0", int'(o_div_active), 2);
    t0 = n_tick;
    repeat (6) step(1, 0, 0, 0, 0);
    chk("s4_tick_every2", n_tick - t0, 3);
    a0 = n_ack;
    step(1, 1, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    chk("s4_ack_once_load1", n_ack - a0, 1);
    chk("s4_clamp1", int'(o_div_active), 2);

    // Enable stall at count=2 with a load during the stall
    step(1, 1, 5, 0, 0);
    run_until("s5_ack_wait", 1, 1);
    start = cyc;
    run_until("s5_count2", 0, 2);
    for (int k = 0; k < 4; k++) begin
      step(0, (k == 1), 4, 0, 0);
      chk("s5_hold_count", int'(o_count), 2);
      chk("s5_no_tick", int'(o_tick), 0);
    end
    run_until("s5_tick_wait", 2, 1);
    chk("s5_period_len", cyc - start, 9);
    chk("s5_ack_at_wrap", int'(o_div_ack), 1);
    chk("s5_div_active", int'(o_div_active), 4);

    // Reset together with a load at count=3
    run_until("s6_count3", 0, 3);
    step(1, 1, 7, 0, 1);
    chk("s6_rst_count", int'(o_count), 0);
    chk("s6_rst_div", int'(o_div_active), 5);
    chk("s6_rst_tick", int'(o_tick), 0);
    chk("s6_rst_ack", int'(o_div_ack), 0);
    chk("s6_rst_clk_out", int'(o_clk_out), 0);
    a0 = n_ack;
    repeat (12) step(1, 0, 0, 0, 0);
    chk("s6_no_ack_after", n_ack - a0, 0);
    chk("s6_div_kept", int'(o_div_active), 5);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
